// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the instruction buffer / dispatch sequencer.
// Optional feature macro: DISPATCH_CTRL_PERF_EN (performance counters).
package dispatch_ctrl_pkg;

  localparam int unsigned DC_DEPTH = 8;
  localparam int unsigned DC_WIDTH = 3;

  // Encoding of the WFI instruction (RISC-V SYSTEM opcode).
  localparam logic [31:0] WFI = 32'h1050_0073;

  typedef enum logic {
    DC_RUN,
    DC_HALTED
  } DISPATCH_STATE;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_ID_PACKET;

  function automatic logic is_wfi(IF_ID_PACKET p);
    return p.inst == WFI;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Fetch/dispatch bus for dispatch_ctrl.
// Optional feature macro: DISPATCH_CTRL_PERF_EN adds the perf counter outputs.
interface dispatch_ctrl_if;
  import dispatch_ctrl_pkg::*;

  logic              squash;
  IF_ID_PACKET [2:0] if_packet_in;
  logic              fetch_stall;
  IF_ID_PACKET [2:0] dis_packet_out;
  logic [2:0]        d_stall;
  logic [1:0]        dispatched_cnt;
  logic              halted;
`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_dispatched;

  modport slave (
    input  squash, if_packet_in, d_stall,
    output fetch_stall, dis_packet_out, dispatched_cnt, halted,
    output perf_stall_cycles, perf_dispatched
  );

  modport master (
    output squash, if_packet_in, d_stall,
    input  fetch_stall, dis_packet_out, dispatched_cnt, halted,
    input  perf_stall_cycles, perf_dispatched
  );
`else
  modport slave (
    input  squash, if_packet_in, d_stall,
    output fetch_stall, dis_packet_out, dispatched_cnt, halted
  );

  modport master (
    output squash, if_packet_in, d_stall,
    input  fetch_stall, dis_packet_out, dispatched_cnt, halted
  );
`endif

endinterface

// File: rtl/dispatch_ctrl_mask.sv
// Combinational in-order prefix mask for the three dispatch slots.
// A slot dispatches only if every older slot dispatches and none of them is a WFI.
module dispatch_ctrl_mask
  import dispatch_ctrl_pkg::*;
(
  input  logic [2:0]    i_exists,
  input  logic [2:0]    i_d_stall,
  input  logic [2:0]    i_wfi,
  input  DISPATCH_STATE i_state,
  input  logic          i_squash,
  output logic [2:0]    o_valid,
  output logic [1:0]    o_cnt,
  output logic          o_wfi_go
);

  logic w_go;

  // Walk slots oldest-first; any blocker closes the gate for all younger slots.
  always_comb begin
    o_valid = '0;
    o_cnt   = '0;
    w_go    = (i_state == DC_RUN) && !i_squash;
    for (int i = 0; i < 3; i++) begin
      w_go       = w_go && i_exists[i] && !i_d_stall[i];
      o_valid[i] = w_go;
      o_cnt      = o_cnt + 2'(w_go);
      w_go       = w_go && !i_wfi[i];
    end
    o_wfi_go = |(o_valid & i_wfi);
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction buffer and in-order dispatch sequencer between fetch and dispatch.
// Circular buffer of DEPTH fetch packets; presents the oldest three to dispatch.
// Optional feature macro: DISPATCH_CTRL_PERF_EN adds stall/dispatch perf counters.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DC_DEPTH,
  parameter int unsigned WIDTH = DC_WIDTH
) (
  input  logic           clock,
  input  logic           reset_n,
  dispatch_ctrl_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  IF_ID_PACKET   r_buf [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  DISPATCH_STATE r_state;

  logic [1:0] w_n_in;
  logic       w_push;
  logic [2:0] w_exists;
  logic [2:0] w_wfi;
  logic [2:0] w_valid;
  logic [1:0] w_cnt;
  logic       w_wfi_go;

  // Conservative: ignores same-cycle pops so the stall never depends on d_stall.
  assign bus.fetch_stall = (CntW'(DEPTH) - r_count) < CntW'(3);
  assign w_push          = !bus.fetch_stall && !bus.squash;
  assign bus.halted      = (r_state == DC_HALTED);
  assign bus.dispatched_cnt = w_cnt;

  // Incoming group size; valids are contiguous from slot 0.
  always_comb begin
    w_n_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_n_in = w_n_in + 2'(bus.if_packet_in[i].valid);
    end
  end

  // Per-slot existence and WFI flags for the oldest entries.
  always_comb begin
    w_exists = '0;
    w_wfi    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_exists[i] = CntW'(i) < r_count;
      w_wfi[i]    = is_wfi(r_buf[r_head + PtrW'(i)]);
    end
  end

  dispatch_ctrl_mask u_mask (
    .i_exists (w_exists),
    .i_d_stall(bus.d_stall),
    .i_wfi    (w_wfi),
    .i_state  (r_state),
    .i_squash (bus.squash),
    .o_valid  (w_valid),
    .o_cnt    (w_cnt),
    .o_wfi_go (w_wfi_go)
  );

  // Output slots carry buffered data; valid comes only from the mask.
  always_comb begin
    bus.dis_packet_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bus.dis_packet_out[i]       = r_buf[r_head + PtrW'(i)];
      bus.dis_packet_out[i].valid = w_valid[i];
    end
  end

  // Buffer storage: write the accepted group at tail onward.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.if_packet_in[i].valid) begin
          r_buf[r_tail + PtrW'(i)] <= bus.if_packet_in[i];
        end
      end
    end
  end

  // Pointers, occupancy and RUN/HALTED sequencing; squash overrides all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= DC_RUN;
    end else if (bus.squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= DC_RUN;
    end else begin
      r_head <= r_head + PtrW'(w_cnt);
      if (w_push) begin
        r_tail <= r_tail + PtrW'(w_n_in);
      end
      r_count <= r_count + (w_push ? CntW'(w_n_in) : CntW'(0)) - CntW'(w_cnt);
      unique case (r_state)
        DC_RUN:    if (w_wfi_go) r_state <= DC_HALTED;
        DC_HALTED: r_state <= DC_HALTED;
        default:   r_state <= DC_RUN;
      endcase
    end
  end

`ifdef DISPATCH_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_disp;

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_dispatched   = r_perf_disp;

  // Free-running wrapping counters of blocked cycles and dispatched entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_disp  <= '0;
    end else begin
      if ((r_count != '0) && (w_cnt == 2'd0) && (r_state == DC_RUN)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      r_perf_disp <= r_perf_disp + 32'(w_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl (DEPTH = 8).
// Perf-counter checks compile in when DISPATCH_CTRL_PERF_EN is defined.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam logic [31:0] ADD = 32'h0000_0033;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  dispatch_ctrl_if bus ();

  dispatch_ctrl #(
    .DEPTH(8),
    .WIDTH(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] valids();
    return {bus.dis_packet_out[2].valid, bus.dis_packet_out[1].valid,
            bus.dis_packet_out[0].valid};
  endfunction

  function automatic IF_ID_PACKET pk(input logic [31:0] pc, input logic [31:0] inst);
    IF_ID_PACKET p;
    p.inst  = inst;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic grp(input logic [31:0] pc, input int n, input logic [31:0] i0,
                     input logic [31:0] i1, input logic [31:0] i2);
    logic [31:0] insts [3];
    insts[0] = i0;
    insts[1] = i1;
    insts[2] = i2;
    bus.if_packet_in = '0;
    for (int k = 0; k < n; k++) begin
      bus.if_packet_in[k] = pk(pc + 32'(4 * k), insts[k]);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 unit later.
  task automatic cyc(input logic [2:0] ds);
    @(negedge clock);
    bus.d_stall      = ds;
    bus.squash       = 1'b0;
    bus.if_packet_in = '0;
    #1;
  endtask

  initial begin
    bus.squash       = 1'b0;
    bus.d_stall      = '0;
    bus.if_packet_in = '0;
    #2;
    chk("rst_fetch_stall", 32'(bus.fetch_stall), 0);
    chk("rst_valids", 32'(valids()), 0);
    chk("rst_cnt", 32'(bus.dispatched_cnt), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic push then full dispatch
    cyc(3'b000); grp(32'h0, 3, ADD, ADD, ADD);
    chk("nobypass_cnt", 32'(bus.dispatched_cnt), 0);
    cyc(3'b000);
    chk("t2_valids", 32'(valids()), 32'h7);
    chk("t2_cnt", 32'(bus.dispatched_cnt), 3);
    chk("t2_pc0", bus.dis_packet_out[0].PC, 32'h0);
    chk("t2_pc1", bus.dis_packet_out[1].PC, 32'h4);
    chk("t2_pc2", bus.dis_packet_out[2].PC, 32'h8);
    cyc(3'b000);
    chk("t3_count", 32'(dut.r_count), 0);
    chk("t3_cnt", 32'(bus.dispatched_cnt), 0);
    grp(32'h0, 3, ADD, ADD, ADD);

    // Partial dispatch against slot-1 stall
    cyc(3'b010);
    chk("ps_valids", 32'(valids()), 32'h1);
    chk("ps_cnt", 32'(bus.dispatched_cnt), 1);
    chk("ps_pc0", bus.dis_packet_out[0].PC, 32'h0);
    cyc(3'b000);
    chk("ps_next_pc0", bus.dis_packet_out[0].PC, 32'h4);
    chk("ps_next_valids", 32'(valids()), 32'h3);
    chk("ps_next_cnt", 32'(bus.dispatched_cnt), 2);

    // Fill under full stall, across the wrap (head/tail start at 6)
    cyc(3'b111);
    chk("f1_fstall", 32'(bus.fetch_stall), 0);
    chk("f1_cnt", 32'(bus.dispatched_cnt), 0);
    grp(32'h20, 3, ADD, ADD, ADD);
    cyc(3'b111);
    chk("f2_count", 32'(dut.r_count), 3);
    chk("f2_fstall", 32'(bus.fetch_stall), 0);
    grp(32'h2c, 3, ADD, ADD, ADD);
    cyc(3'b110);
    chk("f3_count", 32'(dut.r_count), 6);
    chk("f3_fstall", 32'(bus.fetch_stall), 1);
    chk("f3_cnt", 32'(bus.dispatched_cnt), 1);
    chk("f3_pc0", bus.dis_packet_out[0].PC, 32'h20);
    grp(32'h900, 3, ADD, ADD, ADD);  // refused: fetch_stall
    cyc(3'b111);
    chk("f4_fstall", 32'(bus.fetch_stall), 0);
    chk("f4_cnt", 32'(bus.dispatched_cnt), 0);
    grp(32'h38, 3, ADD, ADD, ADD);
    cyc(3'b111);
    chk("full_count", 32'(dut.r_count), 8);
    chk("full_fstall", 32'(bus.fetch_stall), 1);
    grp(32'h500, 3, ADD, ADD, ADD);  // refused: full

    // Drain in order
    cyc(3'b000);
    chk("d1_fstall", 32'(bus.fetch_stall), 1);
    chk("d1_cnt", 32'(bus.dispatched_cnt), 3);
    chk("d1_pc0", bus.dis_packet_out[0].PC, 32'h24);
    chk("d1_pc1", bus.dis_packet_out[1].PC, 32'h28);
    chk("d1_pc2", bus.dis_packet_out[2].PC, 32'h2c);
    cyc(3'b000);
    chk("d2_fstall", 32'(bus.fetch_stall), 0);
    chk("d2_cnt", 32'(bus.dispatched_cnt), 3);
    chk("d2_pc0", bus.dis_packet_out[0].PC, 32'h30);
    chk("d2_pc1", bus.dis_packet_out[1].PC, 32'h34);
    chk("d2_pc2", bus.dis_packet_out[2].PC, 32'h38);
    cyc(3'b000);
    chk("d3_valids", 32'(valids()), 32'h3);
    chk("d3_cnt", 32'(bus.dispatched_cnt), 2);
    chk("d3_pc0", bus.dis_packet_out[0].PC, 32'h3c);
    chk("d3_pc1", bus.dis_packet_out[1].PC, 32'h40);

    // WFI halts dispatch
    cyc(3'b000);
    chk("w0_count", 32'(dut.r_count), 0);
    grp(32'h60, 3, ADD, WFI, ADD);
    cyc(3'b000);
    chk("w1_valids", 32'(valids()), 32'h3);
    chk("w1_cnt", 32'(bus.dispatched_cnt), 2);
    chk("w1_inst1", bus.dis_packet_out[1].inst, WFI);
    chk("w1_halted", 32'(bus.halted), 0);
    cyc(3'b000);
    chk("w2_halted", 32'(bus.halted), 1);
    chk("w2_valids", 32'(valids()), 0);
    chk("w2_cnt", 32'(bus.dispatched_cnt), 0);
    chk("w2_pc0", bus.dis_packet_out[0].PC, 32'h68);
    chk("w2_count", 32'(dut.r_count), 1);
    grp(32'h70, 3, ADD, ADD, ADD);
    cyc(3'b000);
    chk("w3_count", 32'(dut.r_count), 4);
    chk("w3_halted", 32'(bus.halted), 1);
    chk("w3_fstall", 32'(bus.fetch_stall), 0);
    grp(32'h80, 3, ADD, ADD, ADD);
    bus.squash = 1'b1;
    #1;
    chk("w3_sq_cnt", 32'(bus.dispatched_cnt), 0);
    cyc(3'b000);
    chk("w4_count", 32'(dut.r_count), 0);
    chk("w4_halted", 32'(bus.halted), 0);
    grp(32'h90, 3, ADD, ADD, ADD);

    // Squash in RUN with buffered entries and a same-cycle push
    cyc(3'b000);
    grp(32'ha0, 3, ADD, ADD, ADD);
    bus.squash = 1'b1;
    #1;
    chk("sq_cnt", 32'(bus.dispatched_cnt), 0);
    chk("sq_valids", 32'(valids()), 0);
    cyc(3'b000);
    chk("sq_next_count", 32'(dut.r_count), 0);
    chk("sq_next_valids", 32'(valids()), 0);
    grp(32'hb0, 2, ADD, ADD, ADD);

    // Asynchronous reset mid-operation
    cyc(3'b111);
    chk("ar_pre_count", 32'(dut.r_count), 2);
    reset_n = 1'b0;
    #1;
    chk("ar_count", 32'(dut.r_count), 0);
    chk("ar_valids", 32'(valids()), 0);
    @(negedge clock);
    reset_n = 1'b1;

`ifdef DISPATCH_CTRL_PERF_EN
    cyc(3'b111);
    grp(32'h200, 3, ADD, ADD, ADD);
    cyc(3'b111);
    grp(32'h20c, 3, ADD, ADD, ADD);
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111);
    end
    cyc(3'b000);
    cyc(3'b000);
    cyc(3'b000);
    chk("perf_stall", bus.perf_stall_cycles, 32'd5);
    chk("perf_disp", bus.perf_dispatched, 32'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
